// File: rtl/mcntrl_encod_scheduler.sv
// Page-command encoder scheduler.
// Arbitrates page requests from NUM_CHN channels (urgent first, then
// round-robin), loads the winner's page parameters into the shared encoder
// inputs, starts the write or read encoder, waits for its done (or the
// watchdog), and reports completion back to the owning channel.
module mcntrl_encod_scheduler #(
    parameter int NUM_CHN        = 4,
    parameter int CHN_BITS       = 2,
    parameter int ADDRESS_NUMBER = 15,
    parameter int COLADDR_NUMBER = 10,
    parameter int NUM_XFER_BITS  = 6,
    parameter int SEQ_GAP        = 3,
    parameter int TIMEOUT_BITS   = 10
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     enable,
    input  logic [NUM_CHN-1:0]                       chn_req,
    input  logic [NUM_CHN-1:0]                       chn_urgent,
    input  logic [NUM_CHN-1:0]                       chn_dir,
    input  logic [NUM_CHN*3-1:0]                     chn_bank,
    input  logic [NUM_CHN*ADDRESS_NUMBER-1:0]        chn_row,
    input  logic [NUM_CHN*(COLADDR_NUMBER-3)-1:0]    chn_col,
    input  logic [NUM_CHN*NUM_XFER_BITS-1:0]         chn_num128,
    input  logic [NUM_CHN-1:0]                       chn_skip_page,
    output logic [NUM_CHN-1:0]                       chn_grant,
    output logic [NUM_CHN-1:0]                       chn_done,
    output logic                                     busy,
    output logic [CHN_BITS-1:0]                      cur_chn,
    output logic [2:0]                               bank,
    output logic [ADDRESS_NUMBER-1:0]                row,
    output logic [COLADDR_NUMBER-4:0]                start_col,
    output logic [NUM_XFER_BITS-1:0]                 num128,
    output logic                                     skip_next_page,
    output logic                                     start_wr,
    output logic                                     start_rd,
    input  logic                                     done_wr,
    input  logic                                     done_rd,
    output logic                                     timeout_err,
    input  logic                                     clr_err
);

    localparam int COL_W = COLADDR_NUMBER - 3;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_BUSY} state_t;

    state_t                     state_reg, state_next;
    logic [CHN_BITS-1:0]        rr_last_reg;
    logic [3:0]                 gap_reg;
    logic [TIMEOUT_BITS-1:0]    wd_reg;
    logic                       dir_reg;
    logic [CHN_BITS-1:0]        cur_chn_reg;
    logic [2:0]                 bank_reg;
    logic [ADDRESS_NUMBER-1:0]  row_reg;
    logic [COL_W-1:0]           col_reg;
    logic [NUM_XFER_BITS-1:0]   num128_reg;
    logic                       skip_reg;
    logic                       busy_reg;
    logic                       start_wr_reg;
    logic                       start_rd_reg;
    logic [NUM_CHN-1:0]         grant_reg;
    logic [NUM_CHN-1:0]         done_reg;
    logic                       timeout_reg;

    // Per-channel views of the packed request fields
    logic [2:0]                 bank_arr   [NUM_CHN];
    logic [ADDRESS_NUMBER-1:0]  row_arr    [NUM_CHN];
    logic [COL_W-1:0]           col_arr    [NUM_CHN];
    logic [NUM_XFER_BITS-1:0]   num128_arr [NUM_CHN];

    for (genvar gi = 0; gi < NUM_CHN; gi++) begin : g_slice
        assign bank_arr[gi]   = chn_bank[3*gi +: 3];
        assign row_arr[gi]    = chn_row[ADDRESS_NUMBER*gi +: ADDRESS_NUMBER];
        assign col_arr[gi]    = chn_col[COL_W*gi +: COL_W];
        assign num128_arr[gi] = chn_num128[NUM_XFER_BITS*gi +: NUM_XFER_BITS];
    end

    logic [NUM_CHN-1:0]      cand;
    logic                    win_found;
    logic [CHN_BITS-1:0]     win_idx;
    int                      arb_idx;
    logic [NUM_CHN-1:0]      cur_onehot;
    logic                    active_done;
    logic [TIMEOUT_BITS-1:0] wd_inc;
    logic                    wd_expire;
    logic                    arb_fire, start_fire, seq_end, timeout_set;

    assign cur_onehot  = NUM_CHN'(1) << cur_chn_reg;
    assign active_done = dir_reg ? done_wr : done_rd;
    assign wd_inc      = wd_reg + 1'b1;
    assign wd_expire   = &wd_inc;

    // Arbiter: urgent subset if any, then first candidate after rr_last
    always_comb begin
        cand      = ((chn_req & chn_urgent) != '0) ? (chn_req & chn_urgent) : chn_req;
        win_found = 1'b0;
        win_idx   = '0;
        arb_idx   = 0;
        for (int k = 1; k <= NUM_CHN; k++) begin
            arb_idx = int'(rr_last_reg) + k;
            if (arb_idx >= NUM_CHN) begin
                arb_idx = arb_idx - NUM_CHN;
            end
            if (!win_found && cand[CHN_BITS'(arb_idx)]) begin
                win_found = 1'b1;
                win_idx   = CHN_BITS'(arb_idx);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and control strobes
    always_comb begin
        state_next  = state_reg;
        arb_fire    = 1'b0;
        start_fire  = 1'b0;
        seq_end     = 1'b0;
        timeout_set = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable && (gap_reg == 4'd0) && win_found) begin
                    arb_fire   = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                start_fire = 1'b1;
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (active_done) begin
                    seq_end    = 1'b1;
                    state_next = ST_IDLE;
                end else if (wd_expire) begin
                    seq_end     = 1'b1;
                    timeout_set = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: latched page parameters, pulses, gap counter, watchdog.
    // Encoder inputs are latched on the arbitration edge so they are stable
    // a full cycle before the start pulse, and are never cleared afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_reg  <= CHN_BITS'(NUM_CHN - 1);
            gap_reg      <= 4'd0;
            wd_reg       <= '0;
            dir_reg      <= 1'b0;
            cur_chn_reg  <= '0;
            bank_reg     <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            num128_reg   <= '0;
            skip_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            start_wr_reg <= 1'b0;
            start_rd_reg <= 1'b0;
            grant_reg    <= '0;
            done_reg     <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            start_wr_reg <= start_fire & dir_reg;
            start_rd_reg <= start_fire & ~dir_reg;
            grant_reg    <= start_fire ? cur_onehot : '0;
            done_reg     <= seq_end ? cur_onehot : '0;

            if (arb_fire) begin
                cur_chn_reg <= win_idx;
                rr_last_reg <= win_idx;
                dir_reg     <= chn_dir[win_idx];
                bank_reg    <= bank_arr[win_idx];
                row_reg     <= row_arr[win_idx];
                col_reg     <= col_arr[win_idx];
                num128_reg  <= num128_arr[win_idx];
                skip_reg    <= chn_skip_page[win_idx];
            end

            if (arb_fire) begin
                busy_reg <= 1'b1;
            end else if (seq_end) begin
                busy_reg <= 1'b0;
            end

            if (start_fire) begin
                wd_reg <= '0;
            end else if ((state_reg == ST_BUSY) && !seq_end) begin
                wd_reg <= wd_inc;
            end

            if (seq_end) begin
                gap_reg <= 4'(SEQ_GAP);
            end else if ((state_reg == ST_IDLE) && (gap_reg != 4'd0)) begin
                gap_reg <= gap_reg - 4'd1;
            end

            // Clearing wins over a timeout raised in the same cycle
            if (clr_err) begin
                timeout_reg <= 1'b0;
            end else if (timeout_set) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign chn_grant      = grant_reg;
    assign chn_done       = done_reg;
    assign busy           = busy_reg;
    assign cur_chn        = cur_chn_reg;
    assign bank           = bank_reg;
    assign row            = row_reg;
    assign start_col      = col_reg;
    assign num128         = num128_reg;
    assign skip_next_page = skip_reg;
    assign start_wr       = start_wr_reg;
    assign start_rd       = start_rd_reg;
    assign timeout_err    = timeout_reg;

endmodule

// File: doc/mcntrl_encod_scheduler.md
Name: mcntrl_encod_scheduler

Overview:
- Sequences and shares the page command encoders (linear write encoder, matching linear read encoder) among NUM_CHN requesting channels.
- Arbitrates pending page requests (urgent first, then round-robin) and loads the winner's bank/row/col/num128/skip_next_page into the encoder inputs.
- Pulses the proper encoder start, waits for its done, then reports completion to the channel.
- Sits between channel controllers and the encoders, ahead of the command sequencer.

Parameters:
NUM_CHN, 4, number of requesting channels (2..8)
CHN_BITS, 2, width of channel index, must equal clog2(NUM_CHN)
ADDRESS_NUMBER, 15, row address width
COLADDR_NUMBER, 10, column address width; col field is COLADDR_NUMBER-3 bits
NUM_XFER_BITS, 6, transfer length width (0 means 64 bursts)
SEQ_GAP, 3, idle cycles enforced after each completed sequence (0..15)
TIMEOUT_BITS, 10, watchdog counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  allow new grants; 0 finishes current sequence only
chn_req  in  NUM_CHN  per-channel page request (level)
chn_urgent  in  NUM_CHN  per-channel urgent qualifier
chn_dir  in  NUM_CHN  1 = write, 0 = read
chn_bank  in  NUM_CHN*3  packed bank, channel i at [3i+:3]
chn_row  in  NUM_CHN*ADDRESS_NUMBER  packed row
chn_col  in  NUM_CHN*(COLADDR_NUMBER-3)  packed start column
chn_num128  in  NUM_CHN*NUM_XFER_BITS  packed burst count
chn_skip_page  in  NUM_CHN  packed skip_next_page
chn_grant  out  NUM_CHN  one-hot, one-cycle grant pulse
chn_done  out  NUM_CHN  one-hot, one-cycle completion pulse
busy  out  1  sequence in progress
cur_chn  out  CHN_BITS  channel currently owning the encoders (buffer mux select)
bank  out  3  to encoder bank_in
row  out  ADDRESS_NUMBER  to encoder row_in
start_col  out  COLADDR_NUMBER-3  to encoder start_col
num128  out  NUM_XFER_BITS  to encoder num128_in
skip_next_page  out  1  to encoder skip_next_page_in
start_wr  out  1  start pulse to write encoder
start_rd  out  1  start pulse to read encoder
done_wr  in  1  enc_done from write encoder
done_rd  in  1  enc_done from read encoder
timeout_err  out  1  sticky watchdog error
clr_err  in  1  synchronous clear of timeout_err

Behaviour:
- Reset (rst_n=0, async): state IDLE; every output 0; rr_last = NUM_CHN-1 (channel 0 wins first); gap counter 0; watchdog 0.
- FSM: IDLE -> START -> BUSY -> IDLE.
- IDLE: arbitrate when enable=1, gap counter=0, and (chn_req != 0).
  - Candidate set = chn_req & chn_urgent if non-zero, else chn_req.
  - Winner = first candidate searching from rr_last+1, wrapping modulo NUM_CHN.
  - On that edge: latch cur_chn, bank/row/start_col/num128/skip_next_page from winner's slices, direction; rr_last <= winner; busy <= 1; go START.
- START, exactly 1 cycle:
  - start_wr=1 if latched dir=1, else start_rd=1; the other start stays 0.
  - chn_grant[cur_chn]=1.
  - Encoder inputs are stable (valid one cycle before start and held until busy falls).
  - Go BUSY; watchdog cleared.
- BUSY: watchdog increments each cycle.
  - Done of the active encoder (done_wr for write, done_rd for read): chn_done[cur_chn]=1 for 1 cycle; busy <= 0; gap counter <= SEQ_GAP; go IDLE.
  - Done from the inactive encoder is ignored.
  - Watchdog reaches all-ones: timeout_err <= 1, chn_done[cur_chn] pulsed, go IDLE as for normal done.
- Gap counter decrements to 0 in IDLE; no grant while non-zero. SEQ_GAP=0 allows a grant on the cycle after returning to IDLE.
- Requester must drop chn_req by the cycle after chn_grant. chn_req is sampled only in IDLE; a request withdrawn before being granted is lost without effect.
- enable=0 mid-sequence: current sequence completes normally; no new grant until enable=1.
- num128 passes through unchanged (0 = 64 bursts; the encoder interprets it).
- clr_err has priority over a simultaneous timeout set in the same cycle.
- cur_chn and the encoder-input registers hold their last values after completion; they are not cleared.
- Latency from chn_req rising in IDLE (gap 0) to start pulse: 2 cycles.

Test Plan:
- Single request: ch1 write, bank=5, row=0x1234, col=0x20, num128=3, SEQ_GAP=3 -> start_wr at cycle+2 with those values on the outputs, chn_grant=0010. done_wr 10 cycles later -> chn_done=0010 for 1 cycle, busy=0, next grant no earlier than 4 cycles later.
- Round-robin: ch0, ch2, ch3 requesting continuously (re-raising after done) -> grant order 0,2,3,0,2,3.
- Urgent: ch0 and ch3 pending, ch3 urgent, rr_last=3 -> ch3 granted first, then ch0.
- Read path: ch2 read -> start_rd pulse, start_wr stays 0. A spurious done_wr during BUSY is ignored; done_rd completes the sequence.
- Watchdog: TIMEOUT_BITS=4, no done -> timeout_err=1 at 15 cycles after START, chn_done pulsed, FSM back in IDLE. clr_err -> timeout_err=0.
- Reset mid-BUSY: assert rst_n=0 asynchronously -> busy, starts, grants, and dones all 0 immediately. After release, ch0 wins first.
